// File: rtl/data_island_scheduler_if.sv
// Slot/frame/sample handshake bundle between the video timing side
// and the data-island packet scheduler.
interface data_island_scheduler_if;
  logic       frame_start;
  logic       slot_start;
  logic       sample_valid;
  logic [7:0] packet_type;
  logic       packet_valid;
  logic       packet_enable;
  logic       sample_pop;
  logic       overflow;

  modport master (
    output frame_start,
    output slot_start,
    output sample_valid,
    input  packet_type,
    input  packet_valid,
    input  packet_enable,
    input  sample_pop,
    input  overflow
  );

  modport slave (
    input  frame_start,
    input  slot_start,
    input  sample_valid,
    output packet_type,
    output packet_valid,
    output packet_enable,
    output sample_pop,
    output overflow
  );
endinterface

// File: rtl/data_island_scheduler.sv
// Per-slot HDMI data-island packet selector: ACR, audio sample,
// AVI/Audio/SPD InfoFrames or Null, in strict priority order.
module data_island_scheduler #(
  parameter logic [19:0] ACR_PERIOD  = 20'd74250,
  parameter logic [3:0]  MAX_PENDING = 4'd4
) (
  input  logic                           clk_pixel,
  input  logic                           reset_n,
  data_island_scheduler_if.slave         bus
);

  logic [19:0] r_acr_timer;
  logic        r_acr_pending;
  logic [3:0]  r_count;
  logic [2:0]  r_mask;
  logic [7:0]  r_packet_type;
  logic        r_packet_valid;
  logic        r_packet_enable;
  logic        r_sample_pop;
  logic        r_overflow;

  logic        w_wrap;
  logic        w_acr;
  logic        w_aud;
  logic        w_avi;
  logic        w_aif;
  logic        w_spd;
  logic        w_slot;
  logic        w_inc;
  logic        w_dec;
  logic        w_full;
  logic [7:0]  w_type;
  logic [2:0]  w_if_clr;

  assign w_slot = bus.slot_start;
  assign w_wrap = (r_acr_timer == ACR_PERIOD - 20'd1);

  // One-hot selection from pre-edge state
  assign w_acr = r_acr_pending;
  assign w_aud = !r_acr_pending && (r_count != 4'd0);
  assign w_avi = !w_acr && !w_aud && r_mask[0];
  assign w_aif = !w_acr && !w_aud && !r_mask[0] && r_mask[1];
  assign w_spd = !w_acr && !w_aud && (r_mask[1:0] == 2'b00)
                 && r_mask[2];

  assign w_if_clr = w_slot ? {w_spd, w_aif, w_avi} : 3'b000;
  assign w_inc    = bus.sample_valid;
  assign w_dec    = w_slot && w_aud;
  assign w_full   = (r_count == MAX_PENDING);

  always_comb begin
    w_type = 8'h00;
    unique case (1'b1)
      w_acr:   w_type = 8'h01;
      w_aud:   w_type = 8'h02;
      w_avi:   w_type = 8'h82;
      w_aif:   w_type = 8'h84;
      w_spd:   w_type = 8'h83;
      default: w_type = 8'h00;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_acr_timer     <= 20'd0;
      r_acr_pending   <= 1'b0;
      r_count         <= 4'd0;
      r_mask          <= 3'b000;
      r_packet_type   <= 8'h00;
      r_packet_valid  <= 1'b0;
      r_packet_enable <= 1'b0;
      r_sample_pop    <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_acr_timer <= w_wrap ? 20'd0 : r_acr_timer + 20'd1;

      // A wrap re-arms the request even if it is granted this cycle
      if (w_wrap)
        r_acr_pending <= 1'b1;
      else if (w_slot && w_acr)
        r_acr_pending <= 1'b0;

      if (w_dec && !w_inc)
        r_count <= r_count - 4'd1;
      else if (w_inc && !w_dec) begin
        if (w_full)
          r_overflow <= 1'b1;
        else
          r_count <= r_count + 4'd1;
      end

      if (bus.frame_start)
        r_mask <= 3'b111;
      else
        r_mask <= r_mask & ~w_if_clr;

      r_packet_valid  <= w_slot;
      r_packet_enable <= w_dec;
      r_sample_pop    <= w_dec;
      if (w_slot)
        r_packet_type <= w_type;
    end
  end

  assign bus.packet_type   = r_packet_type;
  assign bus.packet_valid  = r_packet_valid;
  assign bus.packet_enable = r_packet_enable;
  assign bus.sample_pop    = r_sample_pop;
  assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler with ACR_PERIOD=100 and
// MAX_PENDING=4; every decision is checked against hand-derived values.
module tb_data_island_scheduler;

  logic clk_pixel;
  logic reset_n;
  int   tests;
  int   fails;

  data_island_scheduler_if u_if ();

  data_island_scheduler #(
    .ACR_PERIOD  (20'd100),
    .MAX_PENDING (4'd4)
  ) u_dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (u_if.slave)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".type"}, {24'd0, u_if.packet_type}, 32'h00);
    chk({tag, ".valid"}, {31'd0, u_if.packet_valid}, 32'd0);
    chk({tag, ".en"}, {31'd0, u_if.packet_enable}, 32'd0);
    chk({tag, ".pop"}, {31'd0, u_if.sample_pop}, 32'd0);
    chk({tag, ".ovf"}, {31'd0, u_if.overflow}, 32'd0);
  endtask

  // Reset is released on a falling edge; the next rising edge is E1.
  task automatic do_reset(input string tag);
    reset_n            = 1'b0;
    u_if.frame_start   = 1'b0;
    u_if.slot_start    = 1'b0;
    u_if.sample_valid  = 1'b0;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    chk_zero(tag);
    reset_n = 1'b1;
  endtask

  task automatic do_slot(input string tag, input logic [7:0] t,
                         input logic en);
    u_if.slot_start = 1'b1;
    tick();
    u_if.slot_start = 1'b0;
    chk({tag, ".valid"}, {31'd0, u_if.packet_valid}, 32'd1);
    chk({tag, ".type"}, {24'd0, u_if.packet_type}, {24'd0, t});
    chk({tag, ".en"}, {31'd0, u_if.packet_enable}, {31'd0, en});
    chk({tag, ".pop"}, {31'd0, u_if.sample_pop}, {31'd0, en});
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Slots every 32 cycles: E32, E64, E96 Null; wrap at E100; E128 ACR
    do_reset("t1.rst");
    idle(31); do_slot("t1.s32", 8'h00, 1'b0);
    tick();
    chk("t1.gap.valid", {31'd0, u_if.packet_valid}, 32'd0);
    idle(30); do_slot("t1.s64", 8'h00, 1'b0);
    idle(31); do_slot("t1.s96", 8'h00, 1'b0);
    idle(31); do_slot("t1.s128", 8'h01, 1'b0);
    idle(31); do_slot("t1.s160", 8'h00, 1'b0);

    // Boundary: slot on the wrap edge sees no request, the next one does
    do_reset("t1b.rst");
    idle(99);
    do_slot("t1b.e100", 8'h00, 1'b0);
    do_slot("t1b.e101", 8'h01, 1'b0);
    do_slot("t1b.e102", 8'h00, 1'b0);

    // InfoFrame rotation after frame_start
    do_reset("t2.rst");
    u_if.frame_start = 1'b1; tick(); u_if.frame_start = 1'b0;
    do_slot("t2.avi", 8'h82, 1'b0);
    tick();
    chk("t2.gap.valid", {31'd0, u_if.packet_valid}, 32'd0);
    chk("t2.gap.hold", {24'd0, u_if.packet_type}, 32'h82);
    do_slot("t2.aif", 8'h84, 1'b0);
    do_slot("t2.spd", 8'h83, 1'b0);
    do_slot("t2.nul", 8'h00, 1'b0);

    // ACR first, then three samples, then InfoFrames
    do_reset("t3.rst");
    u_if.sample_valid = 1'b1; idle(3); u_if.sample_valid = 1'b0;
    idle(97);
    u_if.frame_start = 1'b1; tick(); u_if.frame_start = 1'b0;
    do_slot("t3.acr", 8'h01, 1'b0);
    do_slot("t3.as1", 8'h02, 1'b1);
    do_slot("t3.as2", 8'h02, 1'b1);
    do_slot("t3.as3", 8'h02, 1'b1);
    do_slot("t3.avi", 8'h82, 1'b0);
    do_slot("t3.aif", 8'h84, 1'b0);

    // Saturation at 4 with sticky overflow
    do_reset("t4.rst");
    u_if.sample_valid = 1'b1;
    idle(4);
    chk("t4.ovf4", {31'd0, u_if.overflow}, 32'd0);
    tick();
    chk("t4.ovf5", {31'd0, u_if.overflow}, 32'd1);
    tick();
    u_if.sample_valid = 1'b0;
    do_slot("t4.as1", 8'h02, 1'b1);
    do_slot("t4.as2", 8'h02, 1'b1);
    do_slot("t4.as3", 8'h02, 1'b1);
    do_slot("t4.as4", 8'h02, 1'b1);
    do_slot("t4.nul", 8'h00, 1'b0);
    chk("t4.ovf.end", {31'd0, u_if.overflow}, 32'd1);
    do_reset("t4.rst2");

    // Arrival and grant on the same edge at count 4
    u_if.sample_valid = 1'b1; idle(4);
    u_if.slot_start = 1'b1; tick();
    u_if.slot_start = 1'b0; u_if.sample_valid = 1'b0;
    chk("t5.type", {24'd0, u_if.packet_type}, 32'h02);
    chk("t5.en", {31'd0, u_if.packet_enable}, 32'd1);
    chk("t5.ovf", {31'd0, u_if.overflow}, 32'd0);
    do_slot("t5.as1", 8'h02, 1'b1);
    do_slot("t5.as2", 8'h02, 1'b1);
    do_slot("t5.as3", 8'h02, 1'b1);
    do_slot("t5.as4", 8'h02, 1'b1);
    do_slot("t5.nul", 8'h00, 1'b0);
    chk("t5.ovf.end", {31'd0, u_if.overflow}, 32'd0);

    // Reload beats AVI grant; mid-slot reset clears everything
    do_reset("t6.rst");
    u_if.frame_start = 1'b1; tick();
    u_if.slot_start = 1'b1; tick();
    u_if.slot_start = 1'b0; u_if.frame_start = 1'b0;
    chk("t6.avi1", {24'd0, u_if.packet_type}, 32'h82);
    do_slot("t6.avi2", 8'h82, 1'b0);
    do_slot("t6.aif", 8'h84, 1'b0);
    u_if.slot_start = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("t6.async");
    u_if.slot_start = 1'b0;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    tick();
    chk("t6.nopulse", {31'd0, u_if.packet_valid}, 32'd0);
    do_slot("t6.nomask", 8'h00, 1'b0);
    u_if.frame_start = 1'b1; tick(); u_if.frame_start = 1'b0;
    do_slot("t6.avi3", 8'h82, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
